// File: rtl/hvac_pkg.sv
// Shared definitions for the HVAC sequencer: state encoding, default
// thresholds and dwell times, and the dwell-timer width helper.
package hvac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAT = 2'd1,
        ST_COOL = 2'd2,
        ST_REST = 2'd3
    } hvac_state_t;

    localparam int HEAT_ON_DEF     = 18;
    localparam int HEAT_OFF_DEF    = 20;
    localparam int COOL_ON_DEF     = 22;
    localparam int COOL_OFF_DEF    = 20;
    localparam int MIN_ON_CYC_DEF  = 4;
    localparam int MIN_OFF_CYC_DEF = 2;

    // Width that holds max(on, off); never narrower than one bit.
    function automatic int timer_width(input int on_cyc, input int off_cyc);
        int longest;
        longest = (on_cyc > off_cyc) ? on_cyc : off_cyc;
        if (longest < 1) begin
            longest = 1;
        end
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/hvac_dwell_timer.sv
// Down-counting dwell timer: loads a value on state entry, counts down to
// zero and saturates there. The zero flag gates every state exit.
module hvac_dwell_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             decrement,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load has priority over counting; the count never wraps below zero.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (decrement && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hvac_sequencer.sv
// Heater/cooler sequencer with hysteresis thresholds, minimum run time and
// minimum rest time. Outputs are registered alongside the state so they
// are a pure decode of the state register.
module hvac_sequencer
    import hvac_pkg::*;
#(
    parameter int HEAT_ON     = HEAT_ON_DEF,
    parameter int HEAT_OFF    = HEAT_OFF_DEF,
    parameter int COOL_ON     = COOL_ON_DEF,
    parameter int COOL_OFF    = COOL_OFF_DEF,
    parameter int MIN_ON_CYC  = MIN_ON_CYC_DEF,
    parameter int MIN_OFF_CYC = MIN_OFF_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [4:0] temperature,
    output logic       heating,
    output logic       cooling,
    output logic [1:0] state,
    output logic       lockout
);

    localparam int TW = timer_width(MIN_ON_CYC, MIN_OFF_CYC);

    localparam logic [4:0] HEAT_ON_T  = 5'(HEAT_ON);
    localparam logic [4:0] HEAT_OFF_T = 5'(HEAT_OFF);
    localparam logic [4:0] COOL_ON_T  = 5'(COOL_ON);
    localparam logic [4:0] COOL_OFF_T = 5'(COOL_OFF);

    // A dwell of N cycles loads N-1; a zero dwell still holds one cycle.
    localparam logic [TW-1:0] ON_LOAD  = (MIN_ON_CYC  > 0) ? TW'(MIN_ON_CYC  - 1) : '0;
    localparam logic [TW-1:0] OFF_LOAD = (MIN_OFF_CYC > 0) ? TW'(MIN_OFF_CYC - 1) : '0;

    hvac_state_t   state_q;
    hvac_state_t   next_state;
    logic          timer_load;
    logic [TW-1:0] timer_value;
    logic          timer_zero;

    hvac_dwell_timer #(
        .WIDTH(TW)
    ) u_dwell_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load),
        .load_value(timer_value),
        .decrement (1'b1),
        .zero      (timer_zero)
    );

    // Next-state and timer-load decision; heat wins over cool from IDLE.
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state  = state_q;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state_q)
            ST_IDLE: begin
                if (enable && (temperature < HEAT_ON_T)) begin
                    next_state  = ST_HEAT;
                    timer_load  = 1'b1;
                    timer_value = ON_LOAD;
                end else if (enable && (temperature > COOL_ON_T)) begin
                    next_state  = ST_COOL;
                    timer_load  = 1'b1;
                    timer_value = ON_LOAD;
                end
            end
            ST_HEAT: begin
                if (timer_zero && ((temperature >= HEAT_OFF_T) || !enable)) begin
                    next_state  = ST_REST;
                    timer_load  = 1'b1;
                    timer_value = OFF_LOAD;
                end
            end
            ST_COOL: begin
                if (timer_zero && ((temperature <= COOL_OFF_T) || !enable)) begin
                    next_state  = ST_REST;
                    timer_load  = 1'b1;
                    timer_value = OFF_LOAD;
                end
            end
            ST_REST: begin
                if (timer_zero) begin
                    next_state = ST_IDLE;
                    timer_load = 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            heating <= 1'b0;
            cooling <= 1'b0;
            lockout <= 1'b0;
        end else begin
            state_q <= next_state;
            heating <= (next_state == ST_HEAT);
            cooling <= (next_state == ST_COOL);
            lockout <= (next_state == ST_REST);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_hvac_sequencer.sv
// Directed bench for hvac_sequencer: a per-cycle vector table followed by
// hand-written sequences for reset mid-run and cooling hysteresis.
module tb_hvac_sequencer;

    typedef struct {
        logic       rst;
        logic       en;
        logic [4:0] temp;
        logic [1:0] st;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [4:0] temperature = 5'd0;
    logic       heating;
    logic       cooling;
    logic [1:0] state;
    logic       lockout;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    hvac_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .temperature(temperature),
        .heating    (heating),
        .cooling    (cooling),
        .state      (state),
        .lockout    (lockout)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input int t, input int st, input string name);
        vec_t v;
        v.rst  = r;
        v.en   = e;
        v.temp = 5'(t);
        v.st   = 2'(st);
        v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {state,heat,cool,lock}=%b required %b", name, act, exp);
        end
    endtask

    // One cycle: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic r, input logic e, input int t, input int st, input string name);
        logic [1:0] exp_st;
        logic [4:0] exp_all;
        @(negedge clk);
        rst         = r;
        enable      = e;
        temperature = 5'(t);
        @(posedge clk);
        #1;
        exp_st  = 2'(st);
        exp_all = {exp_st, exp_st == 2'd1, exp_st == 2'd2, exp_st == 2'd3};
        check(name, {state, heating, cooling, lockout}, exp_all);
    endtask

    initial begin
        // Reset, then immediate heat start and hysteresis inside HEAT.
        add(1, 1, 15, 0, "reset_c1");
        add(1, 1, 15, 0, "reset_c2");
        add(0, 1, 15, 1, "heat_start");
        add(0, 1, 15, 1, "heat_min2");
        add(0, 1, 15, 1, "heat_min3");
        add(0, 1, 25, 1, "heat_min4_ignore_hot");
        add(0, 1, 19, 1, "heat_hyst_19");
        add(0, 1, 19, 1, "heat_hyst_19b");
        add(0, 1, 20, 3, "heat_off_20");
        add(0, 1, 20, 3, "rest_2");
        add(0, 1, 21, 0, "rest_to_idle");
        add(0, 1, 21, 0, "idle_21");
        add(0, 1, 22, 0, "idle_cool_on_edge");
        add(0, 1, 18, 0, "idle_heat_on_edge");
        // Cool run with minimum run honoured despite a cold sample.
        add(0, 1, 25, 2, "cool_start");
        add(0, 1, 19, 2, "cool_min2");
        add(0, 1, 19, 2, "cool_min3");
        add(0, 1, 19, 2, "cool_min4");
        add(0, 1, 19, 3, "cool_to_rest");
        add(0, 1, 19, 3, "cool_rest2");
        add(0, 1, 19, 0, "cool_rest_idle");
        // Enable gating and enable dropped early in a run.
        add(0, 0, 10, 0, "dis_cold");
        add(0, 0, 30, 0, "dis_hot");
        add(0, 1, 27, 2, "en_cool_start");
        add(0, 0, 27, 2, "en_drop_min2");
        add(0, 0, 27, 2, "en_drop_min3");
        add(0, 0, 27, 2, "en_drop_min4");
        add(0, 0, 27, 3, "en_drop_rest");
        add(0, 0, 27, 3, "en_drop_rest2");
        add(0, 0, 27, 0, "en_drop_idle");
        // Anti-short-cycle: cold during REST must wait through IDLE.
        add(0, 1, 10, 1, "asc_heat");
        add(0, 1, 10, 1, "asc_heat2");
        add(0, 1, 10, 1, "asc_heat3");
        add(0, 1, 10, 1, "asc_heat4");
        add(0, 1, 20, 3, "asc_rest1");
        add(0, 1, 10, 3, "asc_rest2_cold");
        add(0, 1, 10, 0, "asc_idle_cold");
        add(0, 1, 10, 1, "asc_reheat");

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].temp, vecs[i].st, vecs[i].name);
        end

        // Reset mid-COOL: output drops at the reset edge, no REST period.
        step(1, 1, 20, 0, "mid_rst_pre");
        step(0, 1, 25, 2, "mid_cool1");
        step(1, 1, 25, 0, "mid_cool2_rst");
        step(0, 1, 20, 0, "mid_after_rst_idle");
        // Timer must have been cleared by reset: a fresh run lasts 4 cycles.
        step(0, 1, 25, 2, "post_rst_cool1");
        step(0, 1, 20, 2, "post_rst_cool2");
        step(0, 1, 20, 2, "post_rst_cool3");
        step(0, 1, 20, 2, "post_rst_cool4");
        step(0, 1, 20, 3, "post_rst_rest");
        step(0, 1, 20, 3, "post_rst_rest2");
        step(0, 1, 20, 0, "post_rst_idle");

        // Cooling hysteresis: 21 keeps cooling past min-on, 20 stops it.
        step(0, 1, 23, 2, "chys_start");
        step(0, 1, 21, 2, "chys2");
        step(0, 1, 21, 2, "chys3");
        step(0, 1, 21, 2, "chys4");
        step(0, 1, 21, 2, "chys_hold_21");
        step(0, 1, 20, 3, "chys_off_20");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
